// File: rtl/uart_tx_8n1.sv
// 8N1 UART transmitter: START/DATA/STOP FSM with a BAUD_DIV-cycle bit timer, LSB first, idle high.
// Latency: tx drops one cycle after acceptance. Accepts a byte only while tx_ready=1; there is no queuing.
module uart_tx_8n1 #(
    parameter int BAUD_DIV = 868
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tx_start,
    input  logic [7:0] tx_data,
    output logic       tx_ready,
    output logic       tx_done,
    output logic       tx,
    output logic [1:0] tx_stat
);

    localparam logic [15:0] LAST = 16'(BAUD_DIV - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t      state, state_n;
    logic [15:0] cnt, cnt_n;
    logic [2:0]  idx, idx_n;
    logic [7:0]  shreg, shreg_n;
    logic        bit_end;
    logic        tx_n;

    assign bit_end = (cnt == LAST);

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        idx_n   = idx;
        shreg_n = shreg;
        case (state)
            IDLE: begin
                cnt_n = '0;
                idx_n = '0;
                if (tx_start) begin
                    state_n = START;
                    shreg_n = tx_data;
                end
            end
            START: begin
                if (bit_end) begin
                    state_n = DATA;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + 16'd1;
                end
            end
            DATA: begin
                if (bit_end) begin
                    cnt_n   = '0;
                    shreg_n = {1'b0, shreg[7:1]};
                    if (idx == 3'd7) begin
                        // last data bit done: go to STOP rather than wrapping the index
                        state_n = STOP;
                        idx_n   = '0;
                    end else begin
                        idx_n = idx + 3'd1;
                    end
                end else begin
                    cnt_n = cnt + 16'd1;
                end
            end
            STOP: begin
                if (bit_end) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + 16'd1;
                end
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
                idx_n   = '0;
                shreg_n = '0;
            end
        endcase
    end

    // Outputs are registered from next-state values so they line up with the state they describe.
    always_comb begin
        tx_n = 1'b1;
        case (state_n)
            START:   tx_n = 1'b0;
            DATA:    tx_n = shreg_n[0];
            default: tx_n = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= '0;
            idx      <= '0;
            shreg    <= '0;
            tx       <= 1'b1;
            tx_ready <= 1'b1;
            tx_done  <= 1'b0;
            tx_stat  <= 2'd0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            idx      <= idx_n;
            shreg    <= shreg_n;
            tx       <= tx_n;
            tx_ready <= (state_n == IDLE);
            tx_done  <= (state_n == STOP) && (cnt_n == LAST);
            tx_stat  <= state_n;
        end
    end

endmodule
